load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001: Parameter d_addr_bits, default 6, is the data memory word-address width (64-bit words).
REQ-002: clk  input  1  single clock; all state updates on its rising edge.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: req_valid  input  1  datapath presents a memory request.
REQ-005: req_ready  output  1  unit can accept a request this cycle.
REQ-006: req_we  input  1  1 = store, 0 = load.
REQ-007: req_funct3  input  3  RISC-V width/sign code (load 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; store 000 SB, 001 SH, 010 SW, 011 SD).
REQ-008: req_addr  input  64  byte address.
REQ-009: req_wdata  input  64  store data, right-aligned.
REQ-010: resp_valid  output  1  one-cycle completion pulse.
REQ-011: resp_rdata  output  64  load result, extended to 64 bits.
REQ-012: resp_err  output  1  request rejected (misaligned, out of range or illegal code), valid with resp_valid.
REQ-013: d_mem_we  output  1  data memory write enable.
REQ-014: d_mem_addr  output  d_addr_bits  data memory word address.
REQ-015: d_mem_data  inout  64  shared data bus; memory drives it when d_mem_we=0.

Function
REQ-016: States SHALL be IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-017: A request is accepted on a rising edge with req_valid=1 and req_ready=1; all req_* fields are captured at that edge and later changes are ignored.
REQ-018: Word address = req_addr[d_addr_bits+2:3]; byte lane k = req_addr[2:0] selects bits [8k+7:8k], little-endian.
REQ-019: Error when: any of req_addr[63:d_addr_bits+3] is nonzero; H access with addr[0]≠0; W access with addr[1:0]≠0; D access with addr[2:0]≠0; load with funct3=111; store with funct3[2]=1.
REQ-020: Error request: IDLE -> RESP; no RD/WR cycle; d_mem_we stays 0; resp_err=1, resp_rdata=0.
REQ-021: Load: IDLE -> RD -> RESP; in RD, d_mem_addr=word address, d_mem_we=0, and d_mem_data is registered at the end of RD.
REQ-022: Load result: the selected byte/half/word/double, sign-extended for LB/LH/LW and zero-extended for LBU/LHU/LWU/LD.
REQ-023: SD: IDLE -> WR -> RESP.
REQ-024: SB/SH/SW: IDLE -> RD -> WR -> RESP (read-modify-write); only the addressed lanes are replaced with the low bytes of req_wdata and the other lanes keep their read values.
REQ-025: In WR, d_mem_we=1 for exactly one cycle, and d_mem_addr and d_mem_data are driven from registers, stable for the whole cycle.
REQ-026: d_mem_data SHALL be high-Z whenever d_mem_we=0; the unit never drives the bus in IDLE, RD or RESP.
REQ-027: d_mem_addr=0 in IDLE and RESP.
REQ-028: RESP lasts one cycle with resp_valid=1 and then goes to IDLE; there is no response backpressure.
REQ-029: resp_rdata holds its value until the next response; for stores resp_rdata=0.
REQ-030: Latency counted from the accepting edge to resp_valid high: error 1 cycle; load and SD 2 cycles; SB/SH/SW 3 cycles.
REQ-031: With req_valid held high, the next request is accepted at the first edge in IDLE, i.e. one cycle after resp_valid.

Reset
REQ-032: Reset SHALL be sampled only on a rising clk edge, with priority over all other inputs.
REQ-033: After reset: state IDLE, req_ready=1 once reset=0, resp_valid=0, resp_err=0, resp_rdata=0, d_mem_we=0, d_mem_addr=0, bus high-Z.
REQ-034: Reset during RD, WR or RESP aborts the request: no write after the reset edge and no resp_valid for the aborted request.

Verification
REQ-035: Memory word1=11; LD addr 0x8 -> resp_valid 2 cycles after accept, rdata=11, err=0, d_mem_we never 1.
REQ-036: Word3=0x0E; SB addr 0x19 wdata 0xAB -> RD, WR, RESP sequence and word3=0xAB0E; then LBU 0x19 -> 0xAB, LB 0x19 -> 0xFFFFFFFFFFFFFFAB, LH 0x18 -> 0xFFFFFFFFFFFFAB0E.
REQ-037: LW addr 0x2, then SD addr 0x200 (d_addr_bits=6) -> each gives resp_valid 1 cycle after accept, err=1, rdata=0, d_mem_we=0 throughout.
REQ-038: SH addr 0x0 with reset asserted in WR -> d_mem_we=0 after the reset edge, no resp_valid, req_ready=1 in the first cycle with reset=0.
REQ-039: req_valid held high with a stream of LD 0x0, SD 0x10 (value 7), LD 0x10 -> accepts are spaced per REQ-031, the final rdata=7, and d_mem_data is Z on every cycle with d_mem_we=0.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between a datapath and a single-port, 64-bit-word data memory.
// Narrow stores are read-modify-write. Misaligned, out-of-range and illegal
// requests are answered with an error and never touch memory.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready for a request; bus released, d_mem_addr = 0
//   RD    | memory drives the addressed word; sampled at end of cycle
//   WR    | unit drives the (merged) word onto the bus, d_mem_we = 1
//   RESP  | one-cycle response pulse, then back to IDLE
module load_store_unit #(
  parameter int d_addr_bits = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [2:0]             req_funct3,
  input  logic [63:0]            req_addr,
  input  logic [63:0]            req_wdata,
  output logic                   resp_valid,
  output logic [63:0]            resp_rdata,
  output logic                   resp_err,
  output logic                   d_mem_we,
  output logic [d_addr_bits-1:0] d_mem_addr,
  inout  wire  [63:0]            d_mem_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t                 state_q, state_d;
  logic                   we_q, we_d;
  logic [2:0]             f3_q, f3_d;
  logic [2:0]             lane_q, lane_d;
  logic [d_addr_bits-1:0] waddr_q, waddr_d;
  logic [63:0]            wdata_q, wdata_d;
  logic [63:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic                   req_err;
  logic                   out_of_range;
  logic                   misaligned;
  logic                   illegal;
  logic [63:0]            size_mask;
  logic [5:0]             shamt;
  logic [63:0]            rd_shift;
  logic [63:0]            load_val;
  logic [63:0]            merged;

  // Classify the incoming request; only meaningful while IDLE.
  always_comb begin
    out_of_range = |(req_addr >> (d_addr_bits + 3));
    misaligned   = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      2'b11:   misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
    illegal = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
    req_err = out_of_range | misaligned | illegal;
  end

  // Lane extraction for loads and lane merge for narrow stores, both working
  // on the word currently on the bus (valid during RD).
  always_comb begin
    size_mask = 64'h0;
    case (f3_q[1:0])
      2'b00:   size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    shamt    = {lane_q, 3'b000};
    rd_shift = d_mem_data >> shamt;
    merged   = (d_mem_data & ~(size_mask << shamt)) | ((wdata_q & size_mask) << shamt);
    load_val = 64'h0;
    case (f3_q)
      3'b000:  load_val = {{56{rd_shift[7]}},  rd_shift[7:0]};
      3'b001:  load_val = {{48{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  load_val = {{32{rd_shift[31]}}, rd_shift[31:0]};
      3'b011:  load_val = rd_shift;
      3'b100:  load_val = {56'h0, rd_shift[7:0]};
      3'b101:  load_val = {48'h0, rd_shift[15:0]};
      3'b110:  load_val = {32'h0, rd_shift[31:0]};
      default: load_val = 64'h0;
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          lane_d  = req_addr[2:0];
          waddr_d = req_addr[d_addr_bits+2:3];
          wdata_d = req_wdata;
          if (req_err) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = 64'h0;
          end else if (req_we && (req_funct3[1:0] == 2'b11)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (we_q) begin
          wdata_d = merged;
          state_d = WR;
        end else begin
          rdata_d = load_val;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      WR: begin
        rdata_d = 64'h0;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      lane_q  <= 3'b000;
      waddr_q <= '0;
      wdata_q <= 64'h0;
      rdata_q <= 64'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs are decoded from registered state only; the bus is released
  // whenever the unit is not writing.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    d_mem_we   = (state_q == WR);
    d_mem_addr = ((state_q == RD) || (state_q == WR)) ? waddr_q : '0;
  end

  assign d_mem_data = d_mem_we ? wdata_q : 64'bz;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios followed by randomized requests
// checked against a byte-addressed reference memory.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        d_mem_we;
  logic [5:0]  d_mem_addr;
  wire  [63:0] d_mem_data;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem [64];
  logic [7:0]  ref_bytes [512];
  logic        ld_en;
  logic [5:0]  ld_idx;
  logic [63:0] ld_val;
  logic        prev_done;

  load_store_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .d_mem_we   (d_mem_we),
    .d_mem_addr (d_mem_addr),
    .d_mem_data (d_mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory drives the bus whenever the unit is not writing.
  assign d_mem_data = d_mem_we ? 64'bz : mem[d_mem_addr];

  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_val;
    else if (d_mem_we) mem[d_mem_addr] <= d_mem_data;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_word(input int w);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_bytes[8*w + i];
    return v;
  endfunction

  task automatic set_word(input int w, input logic [63:0] v);
    for (int i = 0; i < 8; i++) ref_bytes[8*w + i] = v[8*i +: 8];
    ld_idx = 6'(w);
    ld_val = v;
    ld_en  = 1'b1;
    @(posedge clk); #1;
    ld_en  = 1'b0;
  endtask

  // Reference behaviour: byte-addressed memory, size = 2^funct3[1:0] bytes.
  task automatic model(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, output logic err, output logic [63:0] rd,
                       output int lat);
    int size;
    int base;
    logic [63:0] v;
    size = 1 << f3[1:0];
    err  = (addr >= 64'd512) || ((addr % 64'(size)) != 0) ||
           (!we && f3 == 3'd7) || (we && f3 > 3'd3);
    rd   = 64'h0;
    base = int'(addr[8:0]);
    if (err) begin
      lat = 1;
    end else if (!we) begin
      v = 64'h0;
      for (int i = 0; i < size; i++) v = v | (64'(ref_bytes[base + i]) << (8*i));
      if (f3 < 3'd3 && v[8*size-1]) v = v | (~64'h0 << (8*size));
      rd  = v;
      lat = 2;
    end else begin
      for (int i = 0; i < size; i++) ref_bytes[base + i] = wd[8*i +: 8];
      lat = (size == 8) ? 2 : 3;
    end
  endtask

  task automatic monitor(input string tag, input logic [5:0] widx);
    if (d_mem_we) begin
      chk({tag, "_waddr"}, 64'(d_mem_addr), 64'(widx));
      chk({tag, "_wdata"}, d_mem_data, ref_word(int'(widx)));
    end else begin
      chk({tag, "_bus_released"}, d_mem_data, mem[d_mem_addr]);
    end
    if (resp_valid || req_ready) chk({tag, "_addr_zero"}, 64'(d_mem_addr), 64'h0);
  endtask

  // Issue one request, follow it to its response and compare with the model.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wd, input logic hold);
    logic        m_err;
    logic [63:0] m_rd;
    int          m_lat;
    int          w;
    int          n;
    int          wcnt;
    model(we, f3, addr, wd, m_err, m_rd, m_lat);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    w = 0;
    while (!req_ready && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    if (prev_done) chk({tag, "_accept_gap"}, 64'(w), 64'd1);
    else chk({tag, "_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = {$urandom, $urandom};
    req_wdata  = {$urandom, $urandom};
    if (!hold) req_valid = 1'b0;
    n = 1;
    wcnt = 0;
    while (!resp_valid && n < 8) begin
      monitor(tag, addr[8:3]);
      if (d_mem_we) wcnt++;
      @(posedge clk); #1;
      n++;
    end
    monitor(tag, addr[8:3]);
    chk({tag, "_latency"}, 64'(n), 64'(m_lat));
    chk({tag, "_err"}, 64'(resp_err), 64'(m_err));
    chk({tag, "_rdata"}, resp_rdata, m_rd);
    chk({tag, "_writes"}, 64'(wcnt), (we && !m_err) ? 64'd1 : 64'd0);
    req_valid = hold;
    prev_done = 1'b1;
  endtask

  initial begin
    logic [63:0] a;
    logic        h;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 64'h0;
    req_wdata  = 64'h0;
    ld_en      = 1'b0;
    ld_idx     = 6'd0;
    ld_val     = 64'h0;
    prev_done  = 1'b0;
    for (int i = 0; i < 64; i++) set_word(i, {$urandom, $urandom});
    set_word(1, 64'd11);
    set_word(3, 64'h0E);
    @(posedge clk); #1;
    reset = 1'b0;

    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    chk("rst_rdata", resp_rdata, 64'h0);
    chk("rst_we", 64'(d_mem_we), 64'd0);
    chk("rst_addr", 64'(d_mem_addr), 64'h0);
    chk("rst_bus", d_mem_data, mem[0]);

    do_req("ld_word1", 1'b0, 3'b011, 64'h8, 64'h0, 1'b0);
    chk("ld_word1_value", resp_rdata, 64'd11);

    do_req("sb_19", 1'b1, 3'b000, 64'h19, 64'hAB, 1'b0);
    chk("sb_19_word3", mem[3], 64'hAB0E);
    do_req("lbu_19", 1'b0, 3'b100, 64'h19, 64'h0, 1'b0);
    chk("lbu_19_value", resp_rdata, 64'hAB);
    do_req("lb_19", 1'b0, 3'b000, 64'h19, 64'h0, 1'b0);
    chk("lb_19_value", resp_rdata, 64'hFFFF_FFFF_FFFF_FFAB);
    do_req("lh_18", 1'b0, 3'b001, 64'h18, 64'h0, 1'b0);
    chk("lh_18_value", resp_rdata, 64'hFFFF_FFFF_FFFF_AB0E);

    do_req("lw_mis", 1'b0, 3'b010, 64'h2, 64'h0, 1'b0);
    chk("lw_mis_err", 64'(resp_err), 64'd1);
    do_req("sd_oor", 1'b1, 3'b011, 64'h200, 64'h1234, 1'b0);
    chk("sd_oor_err", 64'(resp_err), 64'd1);

    do_req("st_ld0", 1'b0, 3'b011, 64'h0, 64'h0, 1'b1);
    do_req("st_sd10", 1'b1, 3'b011, 64'h10, 64'd7, 1'b1);
    do_req("st_ld10", 1'b0, 3'b011, 64'h10, 64'h0, 1'b0);
    chk("st_final_rdata", resp_rdata, 64'd7);
    @(posedge clk); #1;

    // Reset while the SH writes back: data written equals current contents,
    // so the memory is the same whether or not that write lands.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b001;
    req_addr   = 64'h0;
    req_wdata  = {48'h0, ref_word(0)[15:0]};
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_wr_rd_phase", 64'(d_mem_we), 64'd0);
    @(posedge clk); #1;
    chk("rst_wr_wr_phase", 64'(d_mem_we), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_wr_we_after", 64'(d_mem_we), 64'd0);
    chk("rst_wr_no_resp", 64'(resp_valid), 64'd0);
    reset = 1'b0;
    chk("rst_wr_ready", 64'(req_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_wr_quiet_resp", 64'(resp_valid), 64'd0);
      chk("rst_wr_quiet_we", 64'(d_mem_we), 64'd0);
    end

    // Reset while a load is reading.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b011;
    req_addr   = 64'h28;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_rd_ready", 64'(req_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_rd_quiet_resp", 64'(resp_valid), 64'd0);
    end
    prev_done = 1'b0;

    for (int k = 0; k < 200; k++) begin
      a = {55'h0, 6'($urandom), 3'($urandom)};
      if ($urandom_range(0, 9) == 0) a = a | (64'h1 << $urandom_range(9, 63));
      if ($urandom_range(0, 1) == 0) a[2:0] = 3'b000;
      h = (k == 199) ? 1'b0 : 1'($urandom);
      do_req("rnd", 1'($urandom), 3'($urandom), a, {$urandom, $urandom}, h);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_word(i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
